// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, state types and init ROM for the HD44780 controller
package lcd_pkg;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] LINE1    = 8'h80;
    localparam logic [7:0] LINE2    = 8'hC0;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT_SEQ,
        ST_IDLE,
        ST_WRITE,
        ST_WRAP
    } ctrl_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SETUP,
        WR_EHIGH,
        WR_EXEC
    } wr_state_t;

    typedef enum logic [1:0] {
        WAIT_CMD,
        WAIT_INIT1,
        WAIT_CLR
    } wait_sel_t;

    typedef struct packed {
        logic [7:0] cmd;
        wait_sel_t  wait_sel;
    } init_entry_t;

    localparam int INIT_LEN = 7;

    localparam init_entry_t [0:INIT_LEN-1] INIT_ROM = '{
        '{FUNC_SET, WAIT_INIT1},
        '{FUNC_SET, WAIT_CMD},
        '{FUNC_SET, WAIT_CMD},
        '{FUNC_SET, WAIT_CMD},
        '{DISP_ON,  WAIT_CMD},
        '{ENTRY,    WAIT_CMD},
        '{CLEAR,    WAIT_CLR}
    };

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// rtl/lcd_bus_writer.sv - one HD44780 bus write: setup, E pulse, execution wait
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start        accepted only while idle; latches data/rs/wait_sel
//   data, rs     byte and register select for the write
//   wait_sel     which execution wait follows the E pulse
//   idle         writer can accept start this cycle
//   done         one-cycle pulse on the last execution-wait cycle
//   lcd_db/rs/e  registered panel bus outputs
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_E     = 12,
    parameter int T_CMD   = 2000,
    parameter int T_INIT1 = 205000,
    parameter int T_CLR   = 82000
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       rs,
    input  wait_sel_t  wait_sel,
    output logic       idle,
    output logic       done,
    output logic [7:0] lcd_db,
    output logic       lcd_rs,
    output logic       lcd_e
);

    localparam int MAX_WAIT = max2(max2(T_SETUP, T_E), max2(T_CMD, max2(T_INIT1, T_CLR)));
    localparam int CW       = $clog2(MAX_WAIT + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] E_LAST     = CW'(T_E - 1);
    localparam logic [CW-1:0] CMD_LAST   = CW'(T_CMD - 1);
    localparam logic [CW-1:0] INIT1_LAST = CW'(T_INIT1 - 1);
    localparam logic [CW-1:0] CLR_LAST   = CW'(T_CLR - 1);

    wr_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    db_n;
    logic          rs_n, e_n;
    wait_sel_t     wsel, wsel_n;
    logic [CW-1:0] exec_last;

    always_comb begin
        exec_last = CMD_LAST;
        case (wsel)
            WAIT_INIT1: exec_last = INIT1_LAST;
            WAIT_CLR:   exec_last = CLR_LAST;
            default:    exec_last = CMD_LAST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= WR_IDLE;
            cnt    <= '0;
            lcd_db <= 8'h00;
            lcd_rs <= 1'b0;
            lcd_e  <= 1'b0;
            wsel   <= WAIT_CMD;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            lcd_db <= db_n;
            lcd_rs <= rs_n;
            lcd_e  <= e_n;
            wsel   <= wsel_n;
        end
    end

    // DB/RS are only loaded on start, so they stay stable through E high
    // and the execution wait.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        db_n    = lcd_db;
        rs_n    = lcd_rs;
        e_n     = lcd_e;
        wsel_n  = wsel;
        done    = 1'b0;
        idle    = (state == WR_IDLE);
        case (state)
            WR_IDLE: begin
                if (start) begin
                    state_n = WR_SETUP;
                    cnt_n   = '0;
                    db_n    = data;
                    rs_n    = rs;
                    wsel_n  = wait_sel;
                    e_n     = 1'b0;
                end
            end
            WR_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_n = WR_EHIGH;
                    cnt_n   = '0;
                    e_n     = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WR_EHIGH: begin
                if (cnt == E_LAST) begin
                    state_n = WR_EXEC;
                    cnt_n   = '0;
                    e_n     = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WR_EXEC: begin
                if (cnt == exec_last) begin
                    state_n = WR_IDLE;
                    cnt_n   = '0;
                    done    = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = WR_IDLE;
        endcase
    end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// rtl/lcd_hd44780_ctrl.sv - HD44780 2x16 character LCD controller, 8-bit write-only bus
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   init            power-up wait counts only while high
//   enviar          rising edge requests a character write of info
//   limpiar         rising edge requests a display clear
//   info            character code, captured on the enviar rise
//   lcd_db/e/rs/rw  panel bus (rw tied low)
//   busy            low only when idle with nothing pending
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWR   = 750000,
    parameter int T_INIT1 = 205000,
    parameter int T_SETUP = 2,
    parameter int T_E     = 12,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000,
    parameter int COLS    = 16
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       enviar,
    input  logic       limpiar,
    input  logic [7:0] info,
    output logic [7:0] lcd_db,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       busy
);

    localparam int PW  = $clog2(T_PWR + 1);
    localparam int CLW = $clog2(2 * COLS + 1);

    localparam logic [PW-1:0]  PWR_LAST  = PW'(T_PWR - 1);
    localparam logic [2:0]     INIT_LAST = 3'(INIT_LEN - 1);
    localparam logic [CLW-1:0] COL_LINE2 = CLW'(COLS);
    localparam logic [CLW-1:0] COL_END   = CLW'(2 * COLS);

    ctrl_state_t    state, state_n;
    logic [PW-1:0]  pwr_cnt, pwr_cnt_n;
    logic [2:0]     idx, idx_n;
    logic [CLW-1:0] col, col_n;
    logic           send_pend, clr_pend;
    logic [7:0]     data_q;
    logic           env_prev, lim_prev;
    logic           send_take, clr_take;

    logic           wr_start, wr_rs, wr_idle, wr_done;
    logic [7:0]     wr_data;
    wait_sel_t      wr_wsel;
    init_entry_t    rom_e;

    assign rom_e  = INIT_ROM[idx];
    assign lcd_rw = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_PWR_WAIT;
            pwr_cnt   <= '0;
            idx       <= '0;
            col       <= '0;
            send_pend <= 1'b0;
            clr_pend  <= 1'b0;
            data_q    <= 8'h00;
            env_prev  <= 1'b0;
            lim_prev  <= 1'b0;
        end else begin
            state    <= state_n;
            pwr_cnt  <= pwr_cnt_n;
            idx      <= idx_n;
            col      <= col_n;
            env_prev <= enviar;
            lim_prev <= limpiar;
            // One-deep latches: a rise arriving while the flag is set is lost,
            // and the captured byte is not overwritten.
            if (enviar && !env_prev && !send_pend) begin
                send_pend <= 1'b1;
                data_q    <= info;
            end else if (send_take) begin
                send_pend <= 1'b0;
            end
            if (limpiar && !lim_prev && !clr_pend) begin
                clr_pend <= 1'b1;
            end else if (clr_take) begin
                clr_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        state_n   = state;
        pwr_cnt_n = pwr_cnt;
        idx_n     = idx;
        col_n     = col;
        wr_start  = 1'b0;
        wr_data   = 8'h00;
        wr_rs     = 1'b0;
        wr_wsel   = WAIT_CMD;
        send_take = 1'b0;
        clr_take  = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_PWR_WAIT: begin
                if (init) begin
                    if (pwr_cnt == PWR_LAST) begin
                        state_n = ST_INIT_SEQ;
                        idx_n   = '0;
                    end else begin
                        pwr_cnt_n = pwr_cnt + PW'(1);
                    end
                end
            end
            ST_INIT_SEQ: begin
                // Writer is idle for exactly one cycle between ROM entries,
                // which is where the next entry gets launched.
                wr_start = wr_idle;
                wr_data  = rom_e.cmd;
                wr_wsel  = rom_e.wait_sel;
                if (wr_done) begin
                    if (idx == INIT_LAST) begin
                        state_n = ST_IDLE;
                        col_n   = '0;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end
            end
            ST_IDLE: begin
                busy = send_pend || clr_pend;
                if (clr_pend) begin
                    wr_start = 1'b1;
                    wr_data  = CLEAR;
                    wr_wsel  = WAIT_CLR;
                    clr_take = 1'b1;
                    col_n    = '0;
                    state_n  = ST_WRITE;
                end else if (send_pend) begin
                    wr_start  = 1'b1;
                    wr_data   = data_q;
                    wr_rs     = 1'b1;
                    send_take = 1'b1;
                    col_n     = col + CLW'(1);
                    state_n   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wr_done) begin
                    if (col == COL_LINE2) begin
                        state_n = ST_WRAP;
                    end else if (col == COL_END) begin
                        state_n = ST_WRAP;
                        col_n   = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_WRAP: begin
                // col was zeroed on entry only when wrapping back to line 1.
                wr_start = wr_idle;
                wr_data  = (col == '0) ? LINE1 : LINE2;
                if (wr_done) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_PWR_WAIT;
        endcase
    end

    lcd_bus_writer #(
        .T_SETUP (T_SETUP),
        .T_E     (T_E),
        .T_CMD   (T_CMD),
        .T_INIT1 (T_INIT1),
        .T_CLR   (T_CLR)
    ) u_writer (
        .clk      (clk),
        .reset    (reset),
        .start    (wr_start),
        .data     (wr_data),
        .rs       (wr_rs),
        .wait_sel (wr_wsel),
        .idle     (wr_idle),
        .done     (wr_done),
        .lcd_db   (lcd_db),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e)
    );

endmodule
